ysyx_24080006_icache: RTL and testbench

Direct-mapped, blocking instruction cache between the IFU (PC requests) and the IDU-facing fetch buffer, with an AXI4 burst-read master port toward the memory arbiter. Geometry comes from the shared package: `2^IC_M`-byte lines, `2^IC_N` sets and `icache_t` entries. A hit returns one 32-bit word one cycle after the request is accepted. A miss fetches the whole line with one INCR burst and then responds.

---
 rtl/ysyx_24080006_icache_pkg.sv | 54 +++++
 rtl/ysyx_24080006_icache_fill.sv | 92 +++++++++
 rtl/ysyx_24080006_icache.sv | 192 +++++++++++++++++++
 tb/tb_ysyx_24080006_icache.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24080006_icache_pkg.sv
// ysyx_24080006_icache_pkg
//   Shared geometry, storage entry type, AXI4 read-channel bundles and FSM
//   state encoding for the direct-mapped instruction cache.
//   IC_M : log2 of line size in bytes (32-byte lines, 8 words)
//   IC_N : log2 of the number of sets (32 sets)
package ysyx_24080006_icache_pkg;

  localparam int IC_M   = 5;
  localparam int IC_N   = 5;
  localparam int WORDS  = 1 << (IC_M - 2);
  localparam int SETS   = 1 << IC_N;
  localparam int LINE_W = (1 << IC_M) * 8;
  localparam int TAG_W  = 32 - IC_M - IC_N;

  // addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] data;
  } icache_t;

  typedef struct packed {
    logic        arvalid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rready;
  } axi_r_m2s_t;

  typedef struct packed {
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        rlast;
  } axi_r_s2m_t;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    AR,
    R,
    RESP
  } icache_state_e;

  // Select one 32-bit word out of a cache line.
  function automatic logic [31:0] line_word(input logic [LINE_W-1:0] data,
                                            input logic [IC_M-3:0]   sel);
    return data[{sel, 5'b0} +: 32];
  endfunction

endpackage

// File: rtl/ysyx_24080006_icache_fill.sv
// ysyx_24080006_icache_fill
//   AR/R burst sequencer for one cache-line refill. A start pulse latches the
//   line base address and raises ARVALID; after the address handshake every
//   R beat is written into the line assembly register at the current beat
//   position. The beat carrying RLAST ends the burst and produces a one-cycle
//   done pulse; the assembled line is then available on line_o.
//   Ports:
//     clock, reset   : clock, synchronous active-high reset
//     start_i        : begin a refill (one cycle)
//     line_base_i    : address bits [31:IC_M] of the line to fetch
//     axi_r_m2s_o    : AR/R master outputs
//     axi_r_s2m_i    : AR/R slave inputs
//     done_o         : pulse, the burst has finished
//     line_o         : assembled line data
module ysyx_24080006_icache_fill
  import ysyx_24080006_icache_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              start_i,
  input  logic [31:IC_M]    line_base_i,
  output axi_r_m2s_t        axi_r_m2s_o,
  input  axi_r_s2m_t        axi_r_s2m_i,
  output logic              done_o,
  output logic [LINE_W-1:0] line_o
);

  logic              arvalid_q;
  logic              rready_q;
  logic              done_q;
  logic [IC_M-3:0]   beat_q;
  logic [31:IC_M]    base_q;
  logic [LINE_W-1:0] line_q;

  logic ar_fire;
  logic r_fire;

  assign ar_fire = arvalid_q & axi_r_s2m_i.arready;
  assign r_fire  = rready_q & axi_r_s2m_i.rvalid;

  always_ff @(posedge clock) begin
    if (reset) begin
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      done_q    <= 1'b0;
      beat_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        arvalid_q <= 1'b1;
      end else if (ar_fire) begin
        arvalid_q <= 1'b0;
        rready_q  <= 1'b1;
        beat_q    <= '0;
      end
      // RLAST alone ends the burst; the beat counter simply wraps if a
      // non-compliant slave sends more beats than the line holds.
      if (r_fire) begin
        beat_q <= beat_q + 1'b1;
        if (axi_r_s2m_i.rlast) begin
          rready_q <= 1'b0;
          done_q   <= 1'b1;
        end
      end
    end
  end

  // Address and line data carry no reset: they are only observed when the
  // matching valid/done control is set.
  always_ff @(posedge clock) begin
    if (start_i) begin
      base_q <= line_base_i;
    end
    if (r_fire) begin
      line_q[{beat_q, 5'b0} +: 32] <= axi_r_s2m_i.rdata;
    end
  end

  always_comb begin
    axi_r_m2s_o         = '0;
    axi_r_m2s_o.arvalid = arvalid_q;
    axi_r_m2s_o.araddr  = {base_q, {IC_M{1'b0}}};
    axi_r_m2s_o.arlen   = 8'(WORDS - 1);
    axi_r_m2s_o.arsize  = 3'b010;
    axi_r_m2s_o.arburst = 2'b01;
    axi_r_m2s_o.rready  = rready_q;
  end

  assign done_o = done_q;
  assign line_o = line_q;

endmodule

// File: rtl/ysyx_24080006_icache.sv
// ysyx_24080006_icache
//   Direct-mapped blocking instruction cache. One request in flight: a hit
//   answers two cycles after the request is presented, a miss refills the
//   whole line with a single AXI4 INCR burst and then answers from it.
//   Ports:
//     clock, reset          : clock, synchronous active-high reset
//     req_valid/req_ready   : IFU fetch request handshake, req_addr = PC
//     rsp_valid/rsp_ready   : instruction response handshake, rsp_inst = word
//     fence_i               : one-cycle pulse invalidating every line
//     axi_r_m2s / axi_r_s2m : AR/R channels toward the memory arbiter
//     perf_hit / perf_miss  : lookup outcome counters (ICACHE_PERF_EN only)
//   Build option: define ICACHE_PERF_EN to add the hit/miss counters.
module ysyx_24080006_icache
  import ysyx_24080006_icache_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_inst,
  input  logic        rsp_ready,
  input  logic        fence_i,
  output axi_r_m2s_t  axi_r_m2s,
  input  axi_r_s2m_t  axi_r_s2m
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] perf_hit,
  output logic [31:0] perf_miss
`endif
);

  icache_state_e     state_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic [31:0]       rsp_inst_q;
  logic              fence_pend_q;
  logic [31:2]       addr_q;
  icache_t           line_q [SETS];

  logic [IC_N-1:0]   idx;
  logic [TAG_W-1:0]  tag;
  logic [IC_M-3:0]   word;
  icache_t           cur;
  logic              hit;
  logic              fill_start;
  logic              fill_done;
  logic [LINE_W-1:0] fill_line;
  logic              ar_fire;
  logic              leave_r;
  logic              fence_clr;
  logic              unused_addr_lsb;

  // The byte offset inside the word is not needed: the aligned word is returned.
  assign unused_addr_lsb = ^req_addr[1:0];

  assign idx  = addr_q[IC_M+IC_N-1:IC_M];
  assign tag  = addr_q[31:IC_M+IC_N];
  assign word = addr_q[IC_M-1:2];
  assign cur  = line_q[idx];
  assign hit  = cur.valid && (cur.tag == tag);

  assign fill_start = (state_q == LOOKUP) && !hit;
  assign ar_fire    = (state_q == AR) && axi_r_m2s.arvalid && axi_r_s2m.arready;
  assign leave_r    = (state_q == R) && fill_done;

  // A fence seen while the burst is outstanding is deferred until the FSM
  // leaves R, so the freshly filled line is dropped together with the rest.
  assign fence_clr = (fence_i && (state_q == IDLE || state_q == LOOKUP || state_q == RESP))
                  || (leave_r && (fence_pend_q || fence_i));

  ysyx_24080006_icache_fill u_fill (
    .clock       (clock),
    .reset       (reset),
    .start_i     (fill_start),
    .line_base_i (addr_q[31:IC_M]),
    .axi_r_m2s_o (axi_r_m2s),
    .axi_r_s2m_i (axi_r_s2m),
    .done_o      (fill_done),
    .line_o      (fill_line)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_inst_q   <= NOP;
      fence_pend_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            state_q     <= LOOKUP;
            req_ready_q <= 1'b0;
          end
        end
        LOOKUP: begin
          if (hit) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_inst_q  <= line_word(cur.data, word);
          end else begin
            state_q <= AR;
          end
        end
        AR: begin
          if (ar_fire) begin
            state_q <= R;
          end
        end
        R: begin
          if (fill_done) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_inst_q  <= line_word(fill_line, word);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase

      if (leave_r) begin
        fence_pend_q <= 1'b0;
      end else if (fence_i && (state_q == AR || state_q == R)) begin
        fence_pend_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (state_q == IDLE && req_valid) begin
      addr_q <= req_addr[31:2];
    end
  end

  // Line storage: only the valid bits are reset. The fence clear is ordered
  // after the fill write so it wins when both land on the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < SETS; i++) begin
        line_q[i].valid <= 1'b0;
      end
    end else begin
      if (leave_r) begin
        line_q[idx].valid <= 1'b1;
        line_q[idx].tag   <= tag;
        line_q[idx].data  <= fill_line;
      end
      if (fence_clr) begin
        for (int i = 0; i < SETS; i++) begin
          line_q[i].valid <= 1'b0;
        end
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_inst  = rsp_inst_q;

`ifdef ICACHE_PERF_EN
  logic [31:0] perf_hit_q;
  logic [31:0] perf_miss_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_hit_q  <= '0;
      perf_miss_q <= '0;
    end else if (state_q == LOOKUP) begin
      if (hit) begin
        perf_hit_q <= perf_hit_q + 32'd1;
      end else begin
        perf_miss_q <= perf_miss_q + 32'd1;
      end
    end
  end

  assign perf_hit  = perf_hit_q;
  assign perf_miss = perf_miss_q;
`endif

endmodule

// File: tb/tb_ysyx_24080006_icache.sv
module tb_ysyx_24080006_icache;
  import ysyx_24080006_icache_pkg::*;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst_main, rst_slave, reset;
  logic        fence_main, fence_slave, fence_i;
  logic        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [31:0] req_addr, rsp_inst;
  axi_r_m2s_t  m2s;
  axi_r_s2m_t  s2m;
`ifdef ICACHE_PERF_EN
  logic [31:0] perf_hit, perf_miss;
`endif

  assign reset   = rst_main | rst_slave;
  assign fence_i = fence_main | fence_slave;

  ysyx_24080006_icache dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_inst  (rsp_inst),
    .rsp_ready (rsp_ready),
    .fence_i   (fence_i),
    .axi_r_m2s (m2s),
    .axi_r_s2m (s2m)
`ifdef ICACHE_PERF_EN
    ,
    .perf_hit  (perf_hit),
    .perf_miss (perf_miss)
`endif
  );

  int tests = 0;
  int fails = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Backing memory: the line at 0x8000_0000 holds 0x11,0x22,...,0x88.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:5] == 27'h400_0000) return 32'h11 * (32'(a[4:2]) + 32'd1);
    return {a[31:2], 2'b01} ^ 32'h5A5A_0F0F;
  endfunction

  // ---------------- AXI read slave model ----------------
  int          ar_count = 0, beat_cnt = 0, ar_wait = 0, ar_delay = 0;
  int          fence_at_beat = -1, reset_at_beat = -1, rst_fired = 0;
  int          ar_unstable = 0, beats_in_last = 0;
  bit          gaps = 0, in_burst = 0, ar_hs = 0, r_hs = 0, rst_edge = 0;
  logic [31:0] ar_addr_cap = '0;
  logic [7:0]  last_arlen = '0;
  logic [2:0]  last_arsize = '0;
  logic [1:0]  last_arburst = '0;

  initial begin
    s2m = '0;
    fence_slave = 1'b0;
    rst_slave = 1'b0;
    forever begin
      @(negedge clock);
      #1;
      fence_slave = 1'b0;
      rst_slave   = 1'b0;
      if (rst_edge) begin
        in_burst = 0;
      end else begin
        if (ar_hs) begin
          in_burst = 1; beat_cnt = 0; ar_count++; ar_wait = 0;
        end
        if (r_hs) begin
          beat_cnt++;
          if (fence_at_beat == beat_cnt) begin fence_slave = 1'b1; fence_at_beat = -1; end
          if (reset_at_beat == beat_cnt) begin rst_slave = 1'b1; reset_at_beat = -1; rst_fired++; end
          if (s2m.rlast) begin in_burst = 0; beats_in_last = beat_cnt; end
        end
      end
      s2m = '0;
      if (reset) begin
        in_burst = 0; ar_wait = 0; ar_hs = 0; r_hs = 0; rst_edge = 1;
        continue;
      end
      rst_edge = 0;
      if (!in_burst) begin
        if (m2s.arvalid) begin
          if (ar_wait == 0) begin
            ar_addr_cap = m2s.araddr; last_arlen = m2s.arlen;
            last_arsize = m2s.arsize; last_arburst = m2s.arburst;
          end else if (m2s.araddr != ar_addr_cap) begin
            ar_unstable++;
          end
          s2m.arready = (ar_wait >= ar_delay);
          ar_wait++;
        end else begin
          if (ar_wait != 0) ar_unstable++;
          ar_wait = 0;
        end
      end else begin
        s2m.rvalid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        s2m.rdata  = mem_word(ar_addr_cap + 32'(beat_cnt * 4));
        s2m.rlast  = (beat_cnt == 7);
      end
      ar_hs = s2m.arready && m2s.arvalid;
      r_hs  = s2m.rvalid && m2s.rready;
    end
  end

  // ---------------- reference model ----------------
  bit          mvalid [32];
  logic [21:0] mtag   [32];
  int          m_hits = 0, m_misses = 0;

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mvalid[i] = 1'b0;
  endtask

  task automatic fence_pulse();
    fence_main = 1'b1;
    @(negedge clock);
    fence_main = 1'b0;
    model_clear();
  endtask

  task automatic fetch(input logic [31:0] addr, input int hold, output logic [31:0] inst,
                       output int lat, output int nar, output bit ok);
    int a0;
    a0 = ar_count;
    ok = 1'b0; inst = '0; nar = 0;
    check_eq("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_addr  = addr;
    @(negedge clock);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 400) begin
      @(negedge clock);
      lat++;
    end
    if (!rsp_valid) begin
      check_eq("rsp_timeout", 32'd0, 32'd1);
      return;
    end
    inst = rsp_inst;
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      check_eq("hold_inst", rsp_inst, inst);
      check_eq("hold_flags", {30'b0, rsp_valid, req_ready}, 32'h2);
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    check_eq("rsp_done_flags", {30'b0, rsp_valid, req_ready}, 32'h1);
    nar = ar_count - a0;
    ok = 1'b1;
  endtask

  // miss_lat: expected miss latency, 0 when slave timing is randomized.
  task automatic access(input logic [31:0] addr, input int hold, input int miss_lat, input int fence_beat);
    logic [4:0]  idx;
    logic [21:0] tg;
    bit          exp_hit, ok;
    logic [31:0] inst;
    int          lat, nar;
    idx = addr[9:5];
    tg  = addr[31:10];
    exp_hit = mvalid[idx] && (mtag[idx] == tg);
    if (!exp_hit) fence_at_beat = fence_beat;
    fetch(addr, hold, inst, lat, nar, ok);
    fence_at_beat = -1;
    if (ok) begin
      check_eq("inst", inst, mem_word({addr[31:2], 2'b00}));
      check_eq("bursts", 32'(nar), exp_hit ? 32'd0 : 32'd1);
      if (exp_hit) check_eq("hit_latency", 32'(lat), 32'd2);
      else if (miss_lat != 0) check_eq("miss_latency", 32'(lat), 32'(miss_lat));
    end
    mvalid[idx] = 1'b1;
    mtag[idx]   = tg;
    if (exp_hit) m_hits++; else m_misses++;
    if (!exp_hit && fence_beat > 0) model_clear();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          a0, n;
    logic [31:0] addr;
    rst_main = 1'b1; fence_main = 1'b0;
    req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    model_clear();
    repeat (3) @(negedge clock);
    check_eq("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check_eq("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check_eq("rst_rsp_inst", rsp_inst, NOP);
    check_eq("rst_arvalid", {31'b0, m2s.arvalid}, 32'd0);
    check_eq("rst_rready", {31'b0, m2s.rready}, 32'd0);
    rst_main = 1'b0;
    @(negedge clock);

    // cold miss then hit in the same line
    access(32'h8000_0004, 0, 12, -1);
    check_eq("cold_araddr", ar_addr_cap, 32'h8000_0000);
    check_eq("cold_arlen", 32'(last_arlen), 32'd7);
    check_eq("cold_arsize", 32'(last_arsize), 32'd2);
    check_eq("cold_arburst", 32'(last_arburst), 32'd1);
    check_eq("cold_beats", 32'(beats_in_last), 32'd8);
    access(32'h8000_001C, 0, 12, -1);

    // conflict eviction on set 0
    fence_pulse();
    a0 = ar_count;
    access(32'h8000_0000, 0, 12, -1);
    access(32'h8000_0400, 0, 12, -1);
    access(32'h8000_0000, 0, 12, -1);
    check_eq("conflict_bursts", 32'(ar_count - a0), 32'd3);

    // fence during fill: response delivered, then miss again
    access(32'h8000_0048, 0, 12, 3);
    access(32'h8000_0048, 0, 12, -1);

    // response backpressure on a hit, AR backpressure on a miss
    access(32'h8000_004C, 5, 12, -1);
    ar_delay = 4;
    a0 = ar_unstable;
    access(32'h8000_0810, 0, 16, -1);
    check_eq("araddr_stable", 32'(ar_unstable - a0), 32'd0);
    ar_delay = 0;

    // reset at beat 5 of a fill
    reset_at_beat = 5;
    a0 = rst_fired;
    req_valid = 1'b1; req_addr = 32'h8000_0084;
    @(negedge clock);
    req_valid = 1'b0;
    n = 0;
    while (rst_fired == a0 && n < 100) begin @(negedge clock); n++; end
    reset_at_beat = -1;
    check_eq("reset_fired", 32'(rst_fired - a0), 32'd1);
    check_eq("midrst_flags", {28'b0, req_ready, rsp_valid, m2s.arvalid, m2s.rready}, 32'h8);
    model_clear();
    m_hits = 0; m_misses = 0;
    @(negedge clock);
    access(32'h8000_0084, 0, 12, -1);

    // randomized traffic
    for (int it = 0; it < 80; it++) begin
      ar_delay = $urandom_range(0, 3);
      gaps = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 9) == 0) fence_pulse();
      addr = 32'h8000_0000 | (32'($urandom_range(0, 2)) << 10) | (32'($urandom_range(0, 3)) << 5)
           | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      access(addr, $urandom_range(0, 2), (ar_delay == 0 && !gaps) ? 12 : 0,
             ($urandom_range(0, 6) == 0) ? $urandom_range(1, 8) : -1);
    end
    ar_delay = 0;
    gaps = 0;

`ifdef ICACHE_PERF_EN
    rst_main = 1'b1;
    @(negedge clock);
    rst_main = 1'b0;
    model_clear();
    m_hits = 0; m_misses = 0;
    @(negedge clock);
    access(32'h8000_0100, 0, 12, -1);
    access(32'h8000_0104, 0, 12, -1);
    access(32'h8000_0108, 0, 12, -1);
    access(32'h8000_010C, 0, 12, -1);
    check_eq("perf_miss", perf_miss, 32'(m_misses));
    check_eq("perf_hit", perf_hit, 32'(m_hits));
    check_eq("perf_miss_abs", perf_miss, 32'd1);
    check_eq("perf_hit_abs", perf_hit, 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
